// File: rtl/incoming_buf_pkg.sv
// Shared types and sizing helpers for the incoming AXI R-beat buffer.
package incoming_buf_pkg;

  localparam int ID_WIDTH_DEF   = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int RESP_WIDTH_DEF = 2;
  localparam int DEPTH_DEF      = 16;

  localparam int PTR_W = (DEPTH_DEF <= 2) ? 1 : $clog2(DEPTH_DEF);
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);

  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [RESP_WIDTH_DEF-1:0] resp;
    logic                      last;
  } r_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/r_if.sv
// AXI R channel bundle: beats flow from sender to receiver under valid/ready.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport sender   (output id, data, resp, last, valid, input ready);
  modport receiver (input id, data, resp, last, valid, output ready);
endinterface

// File: rtl/incoming_response_buffer_rob_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the incoming R-beat FIFO; flags are
// decoded straight from the registered count.
module rob_fifo_ctrl
  import incoming_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = PTR_W,
  parameter int CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          full,
  output logic          empty
);

  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers wrap at DEPTH-1 independently so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/incoming_response_buffer.sv
// Incoming AXI R-beat FIFO with complete-burst tracking. Define
// INCOMING_STORE_FORWARD_EN to hold beats until a full burst is buffered.
module incoming_response_buffer
  import incoming_buf_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RESP_WIDTH = RESP_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  r_if.receiver                      r_in,
  r_if.sender                        r_out,
  output logic                       Incoming_buffer_full,
  output logic [$clog2(DEPTH+1)-1:0] burst_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          out_valid;

  rob_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .full   (full),
    .empty  (empty)
  );

  assign r_in.ready = ~full;
  assign push       = r_in.valid & ~full;
  assign head       = mem[rd_ptr];

`ifdef INCOMING_STORE_FORWARD_EN
  // Full forces release so a burst longer than DEPTH cannot deadlock.
  assign out_valid = ~empty & ((burst_count != '0) | full);
`else
  assign out_valid = ~empty;
`endif

  assign pop         = out_valid & r_out.ready;
  assign r_out.valid = out_valid;
  assign r_out.id    = head.id;
  assign r_out.data  = head.data;
  assign r_out.resp  = head.resp;
  assign r_out.last  = head.last;

  assign Incoming_buffer_full = full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{id: r_in.id, data: r_in.data, resp: r_in.resp, last: r_in.last};
    end
  end

  // A burst counts as stored from the push of its last beat until that beat pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_count <= '0;
    end else begin
      case ({push & r_in.last, pop & head.last})
        2'b10:   burst_count <= burst_count + 1'b1;
        2'b01:   burst_count <= burst_count - 1'b1;
        default: burst_count <= burst_count;
      endcase
    end
  end

endmodule

// File: tb/tb_incoming_response_buffer.sv
// Directed table plus hand-written sequences for the incoming R-beat buffer.
module tb_incoming_response_buffer;

  logic       clk;
  logic       rst;
  logic       full;
  logic [4:0] burst_count;

  int n_checks = 0;
  int n_fail   = 0;

  r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) in_bus ();
  r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) out_bus ();

  incoming_response_buffer #(
    .ID_WIDTH   (4),
    .DATA_WIDTH (64),
    .RESP_WIDTH (2),
    .DEPTH      (16)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .r_in                 (in_bus),
    .r_out                (out_bus),
    .Incoming_buffer_full (full),
    .burst_count          (burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [63:0] in_data;
    logic        out_ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_last;
    logic [4:0]  exp_burst;
  } vec_t;

  vec_t vecs [7];
  logic [63:0] q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    in_bus.valid = v;
    in_bus.data  = d;
    in_bus.last  = l;
    in_bus.id    = 4'd3;
    in_bus.resp  = 2'd0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int  idx;
    int  popped;
    bit  released;
    bit  accept;

    // reset held with valid=1, then the 4-beat burst id=3 passing straight through
    vecs[0] = '{1'b1, 1'b1, 1'b1, 64'h55, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 5'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 64'hA0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 5'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 64'hA1, 1'b1, 1'b1, 1'b1, 64'hA0, 1'b0, 5'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 64'hA2, 1'b1, 1'b1, 1'b1, 64'hA1, 1'b0, 5'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 64'hA3, 1'b1, 1'b1, 1'b1, 64'hA2, 1'b0, 5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA3, 1'b1, 5'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 5'd0};

    rst = 1'b1;
    out_bus.ready = 1'b0;
    drive(1'b0, 64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++) begin
      rst = vecs[k].rst;
      drive(vecs[k].in_valid, vecs[k].in_data, vecs[k].in_last);
      out_bus.ready = vecs[k].out_ready;
      #1;
      check($sformatf("vec%0d_in_ready", k), 64'(in_bus.ready), 64'(vecs[k].exp_ready));
      check($sformatf("vec%0d_out_valid", k), 64'(out_bus.valid), 64'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        check($sformatf("vec%0d_out_data", k), out_bus.data, vecs[k].exp_data);
        check($sformatf("vec%0d_out_last", k), 64'(out_bus.last), 64'(vecs[k].exp_last));
        check($sformatf("vec%0d_out_id", k), 64'(out_bus.id), 64'd3);
      end
      check($sformatf("vec%0d_burst", k), 64'(burst_count), 64'(vecs[k].exp_burst));
      check($sformatf("vec%0d_full", k), 64'(full), 64'd0);
      tick();
    end
    rst = 1'b0;

    // fill with 16 single-beat bursts while the consumer stalls
    out_bus.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 64'h10 + 64'(i), 1'b1);
      #1;
      check($sformatf("fill%0d_in_ready", i), 64'(in_bus.ready), 64'd1);
      tick();
    end
    drive(1'b1, 64'h99, 1'b1);
    out_bus.ready = 1'b1;
    #1;
    check("full_flag", 64'(full), 64'd1);
    check("full_in_ready", 64'(in_bus.ready), 64'd0);
    check("full_burst", 64'(burst_count), 64'd16);
    check("full_out_valid", 64'(out_bus.valid), 64'd1);
    check("full_out_data", out_bus.data, 64'h10);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    #1;
    check("after_pop_full", 64'(full), 64'd0);
    check("after_pop_in_ready", 64'(in_bus.ready), 64'd1);
    check("after_pop_burst", 64'(burst_count), 64'd15);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(out_bus.valid), 64'd1);
      check($sformatf("drain%0d_data", i), out_bus.data, 64'h10 + 64'(i));
      tick();
    end
    check("drain_empty_valid", 64'(out_bus.valid), 64'd0);
    check("drain_empty_burst", 64'(burst_count), 64'd0);

    // streaming across the pointer wrap with two beats of occupancy
    pulse_reset();
    q.delete();
    out_bus.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h40 + 64'(i), 1'b0);
      q.push_back(64'h40 + 64'(i));
      tick();
    end
    out_bus.ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 64'h42 + 64'(i), 1'b0);
      #1;
      check($sformatf("stream%0d_valid", i), 64'(out_bus.valid), 64'd1);
      check($sformatf("stream%0d_data", i), out_bus.data, q[0]);
      check($sformatf("stream%0d_in_ready", i), 64'(in_bus.ready), 64'd1);
      q.push_back(64'h42 + 64'(i));
      void'(q.pop_front());
      tick();
    end
    drive(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stream_tail%0d_data", i), out_bus.data, q.pop_front());
      check($sformatf("stream_tail%0d_valid", i), 64'(out_bus.valid), 64'd1);
      tick();
    end
    check("stream_end_valid", 64'(out_bus.valid), 64'd0);

`ifdef INCOMING_STORE_FORWARD_EN
    // store-and-forward: nothing leaves until the last beat is stored
    pulse_reset();
    out_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hB0 + 64'(i), 1'b0);
      #1;
      check($sformatf("sf_hold%0d_valid", i), 64'(out_bus.valid), 64'd0);
      tick();
    end
    drive(1'b1, 64'hB3, 1'b1);
    #1;
    check("sf_last_cycle_valid", 64'(out_bus.valid), 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sf_drain%0d_valid", i), 64'(out_bus.valid), 64'd1);
      check($sformatf("sf_drain%0d_data", i), out_bus.data, 64'hB0 + 64'(i));
      tick();
    end
    check("sf_drain_end_valid", 64'(out_bus.valid), 64'd0);

    // burst longer than the buffer must escape through the full term
    pulse_reset();
    out_bus.ready = 1'b1;
    idx = 0;
    popped = 0;
    released = 1'b0;
    for (int cyc = 0; cyc < 100 && idx < 20; cyc++) begin
      drive(1'b1, 64'hC00 + 64'(idx), idx == 19);
      #1;
      if (out_bus.valid && !released) begin
        released = 1'b1;
        check("sf_release_when_full", 64'(full), 64'd1);
      end
      if (out_bus.valid) begin
        check($sformatf("sf_long_pop%0d", popped), out_bus.data, 64'hC00 + 64'(popped));
        popped++;
      end
      accept = in_bus.ready;
      tick();
      if (accept) idx++;
    end
    drive(1'b0, 64'h0, 1'b0);
    check("sf_long_all_pushed", 64'(idx), 64'd20);
    check("sf_long_released", 64'(released), 64'd1);
    #1;
    check("sf_long_drain_valid", 64'(out_bus.valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("sf_rst_valid", 64'(out_bus.valid), 64'd0);
    check("sf_rst_in_ready", 64'(in_bus.ready), 64'd1);
    check("sf_rst_burst", 64'(burst_count), 64'd0);
    check("sf_rst_full", 64'(full), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/incoming_response_buffer.md
Name: incoming_response_buffer

Overview:
DEPTH-entry FIFO for AXI R beats on the incoming side, from the AXI slave back toward the read-response reordering logic. It is the return-path counterpart of the outgoing AR request buffer. It accepts R beats from the slave and presents them in arrival order to the reorder side. It tracks complete bursts (beats carrying last) so that burst-level status is available to the reorder logic.

Parameters:
ID_WIDTH, 4, width of r.id
DATA_WIDTH, 64, width of r.data
RESP_WIDTH, 2, width of r.resp
DEPTH, 16, number of beat entries; must be >= 2

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
r_in  r_if.receiver  interface  R beats from AXI slave (id, data, resp, last, valid, ready)
r_out  r_if.sender  interface  R beats toward reorder logic (same fields)
Incoming_buffer_full  output  1  high when count == DEPTH
burst_count  output  $clog2(DEPTH+1)  number of complete bursts (last beats) currently stored

Behaviour:
- Reset:
  - Synchronous: sampled on posedge clk while rst = 1.
  - wr_ptr, rd_ptr, count and burst_count all go to 0.
  - r_out.valid = 0, r_in.ready = 1, Incoming_buffer_full = 0, burst_count = 0.
  - Storage is not reset. r_out id/data/resp/last are don't-care while r_out.valid = 0.
  - A reset mid-burst drops all stored beats. No partial-burst state survives.
- Handshake:
  - r_in.ready = ~full. There is no combinational dependence on r_out.ready.
  - push = r_in.valid & r_in.ready.
  - pop = r_out.valid & r_out.ready.
  - r_out.valid holds until accepted. Payload is stable while valid & ~ready.
- Latency:
  - A beat pushed in cycle N is visible on r_out in cycle N+1 at the earliest (cut-through mode).
  - There is no same-cycle bypass.
- Ordering: strict FIFO. Beats are never reordered and ids are not inspected.
- Pointers: rd_ptr and wr_ptr wrap from DEPTH-1 to 0 independently.
- count:
  - push only: +1. pop only: -1. Both or neither: unchanged.
- burst_count:
  - Increments on push of a beat with last = 1.
  - Decrements on pop of a beat with last = 1.
  - Both in the same cycle: unchanged.
- Full: push is blocked, and pop in the same cycle does not enable a push that cycle. Ready rises the cycle after count drops below DEPTH.
- Empty: r_out.valid = 0. A push in the same cycle is stored and appears the next cycle.
- Flags are combinational from registered count and burst_count.

Optional Feature:
- INCOMING_STORE_FORWARD_EN defined:
  - r_out.valid = ~empty & ((burst_count != 0) | full).
  - Beats are released only once a complete burst is buffered.
  - The full term is a forced cut-through escape. It prevents deadlock when a burst is longer than DEPTH.
- Macro undefined: r_out.valid = ~empty (pure cut-through). burst_count is still maintained.

Decomposition:
- Package incoming_buf_pkg holds:
  - r_entry_t, a packed struct {id, data, resp, last} parameterised by the widths.
  - Localparams PTR_W = (DEPTH<=2)?1:$clog2(DEPTH) and CNT_W = $clog2(DEPTH+1).
- One natural sub-module: rob_fifo_ctrl. It holds pointers, count, wrap logic and the full/empty flags.
- The storage array, burst_count and the valid gating stay in the top.

Test Plan:
1. Reset with r_in.valid = 1 held -> ready = 1, r_out.valid = 0, burst_count = 0; the first push lands one cycle after rst deasserts.
2. Push 4-beat burst id=3, data 0xA0..0xA3, last on beat 3, with r_out.ready = 1 -> cut-through: beats exit in order starting the cycle after the first push, and burst_count returns to 0.
3. Push 16 single-beat bursts with r_out.ready = 0 -> Incoming_buffer_full = 1, ready = 0, burst_count = 16; the 17th beat is not accepted; one pop then raises ready the next cycle.
4. Continuous push and pop for 40 beats (wrap twice) -> count is constant, output data sequence equals input sequence, with no drops or duplicates.
5. With INCOMING_STORE_FORWARD_EN: push 3 beats without last -> r_out.valid stays 0; push the last beat -> valid rises the next cycle and all 4 beats drain.
6. With INCOMING_STORE_FORWARD_EN: a 20-beat burst -> valid asserts when count = 16 (forced release) and the burst completes with no deadlock; assert rst mid-drain -> count = 0 and valid = 0 the next cycle.
